// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: shows a double-buffered frame of hex digits one digit at a time.
// Latency: outputs are registered and change on the same edge as the scan state; frame writes show from the next frame.
// Backpressure: wr_ready is low while a frame is pending; it clears when the frame is copied to the display.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    input  logic [NUM_DIGITS-1:0]   wr_dp,
    input  logic [2:0]              brightness,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_done
);

    // Lit window is an integer number of eighths of the non-blank part of a slot.
    localparam int CW   = $clog2(SCAN_DIV);
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int STEP = (SCAN_DIV - BLANK_CYCLES) / 8;

    localparam logic [CW-1:0]         CNT_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]         BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIG_ONE    = NUM_DIGITS'(1);

    // Parameter sanity: reject configurations the slot timing cannot represent.
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_chk_digits
        $error("seg_scan_ctrl: NUM_DIGITS must be in 1..8");
    end
    if (BLANK_CYCLES < 1) begin : g_chk_blank
        $error("seg_scan_ctrl: BLANK_CYCLES must be at least 1");
    end
    if ((SCAN_DIV - BLANK_CYCLES) <= 0 || ((SCAN_DIV - BLANK_CYCLES) % 8) != 0) begin : g_chk_div
        $error("seg_scan_ctrl: SCAN_DIV - BLANK_CYCLES must be positive and a multiple of 8");
    end

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_BLANK = 2'd1,
        S_LIT   = 2'd2,
        S_DARK  = 2'd3
    } state_t;

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] data;
        logic [NUM_DIGITS-1:0]   dp;
    } frame_t;

    // Hex digit to segments g..a.
    function automatic logic [6:0] seg7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   on_len_q, on_len_d;
    logic [CW-1:0]   on_len_new;
    logic [CW-1:0]   lit_last;
    logic            slot_end;
    logic            last_digit;
    logic            copy;

    frame_t          pend_q, pend_d;
    logic            pend_full_q, pend_full_d;
    frame_t          act_q, act_d;

    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;
    logic                  done_q, done_d;

    assign on_len_new = CW'((32'(brightness) + 32'd1) * 32'(STEP));
    assign lit_last   = BLANK_LAST + on_len_q;
    assign last_digit = (idx_q == IDX_LAST);

    // State, counters, frame buffers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_OFF;
            cnt_q       <= '0;
            idx_q       <= '0;
            on_len_q    <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            act_q       <= '0;
            seg_q       <= '0;
            dig_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            on_len_q    <= on_len_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            act_q       <= act_d;
            seg_q       <= seg_d;
            dig_q       <= dig_d;
            done_q      <= done_d;
        end
    end

    // Next scan state: blank, lit window, dark remainder; slot end advances to the next digit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        on_len_d = on_len_q;
        slot_end = 1'b0;
        if (!ena) begin
            state_d = S_OFF;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_OFF: begin
                    state_d  = S_BLANK;
                    cnt_d    = '0;
                    idx_d    = '0;
                    on_len_d = on_len_new;
                end
                S_BLANK: begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == BLANK_LAST) begin
                        state_d = S_LIT;
                    end
                end
                S_LIT: begin
                    if (cnt_q == lit_last) begin
                        // Full brightness fills the slot, so there is no dark phase.
                        if (lit_last == CNT_LAST) begin
                            slot_end = 1'b1;
                        end else begin
                            state_d = S_DARK;
                            cnt_d   = cnt_q + CW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_DARK: begin
                    if (cnt_q == CNT_LAST) begin
                        slot_end = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = S_OFF;
                end
            endcase
            if (slot_end) begin
                state_d  = S_BLANK;
                cnt_d    = '0;
                idx_d    = last_digit ? '0 : idx_q + IW'(1);
                on_len_d = on_len_new;
            end
        end
    end

    // Frame port: one pending buffer, promoted to the display only at a frame boundary or while off.
    always_comb begin
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        act_d       = act_q;
        copy        = pend_full_q && ((state_q == S_OFF) || (slot_end && last_digit));
        if (copy) begin
            act_d       = pend_q;
            pend_full_d = 1'b0;
        end else if (wr_valid && !pend_full_q) begin
            pend_d.data = wr_data;
            pend_d.dp   = wr_dp;
            pend_full_d = 1'b1;
        end
    end

    // Output values for the coming cycle, taken from the next state so they switch with it.
    always_comb begin
        seg_d  = '0;
        dig_d  = '0;
        done_d = slot_end && last_digit;
        if (state_d == S_LIT) begin
            dig_d = DIG_ONE << idx_d;
            seg_d = {act_q.dp[idx_d], seg7(act_q.data[{idx_d, 2'b00} +: 4])};
        end
    end

    assign seg_out    = seg_q;
    assign dig_en     = dig_q;
    assign frame_done = done_q;
    assign wr_ready   = ~pend_full_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=20, BLANK_CYCLES=4.
// Every cycle of each checked slot is compared against hand-derived digit/segment values.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic [3:0]  wr_dp;
    logic [2:0]  brightness;
    logic [7:0]  seg_out;
    logic [3:0]  dig_en;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    seg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .SCAN_DIV    (20),
        .BLANK_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .wr_dp     (wr_dp),
        .brightness(brightness),
        .seg_out   (seg_out),
        .dig_en    (dig_en),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] d, input logic [7:0] s,
                              input logic dn, input logic rdy);
        check({tag, ".dig"},  {4'b0, dig_en},     {4'b0, d});
        check({tag, ".seg"},  seg_out,            s);
        check({tag, ".done"}, {7'b0, frame_done}, {7'b0, dn});
        check({tag, ".rdy"},  {7'b0, wr_ready},   {7'b0, rdy});
    endtask

    task automatic cyc(input string tag, input logic [3:0] d, input logic [7:0] s,
                       input logic dn, input logic rdy);
        @(posedge clk);
        #1;
        check_outs(tag, d, s, dn, rdy);
    endtask

    // One full 20-cycle slot: blank 0..3, lit for len cycles from 4, dark to 19.
    task automatic expect_slot(input string tag, input logic [3:0] d, input logic [7:0] s,
                               input int len, input logic done0, input logic rdy0,
                               input logic rdy1, input int br_at, input logic [2:0] br_new);
        for (int c = 0; c < 20; c++) begin
            logic on;
            on = (c >= 4) && (c < 4 + len);
            cyc($sformatf("%s.c%0d", tag, c), on ? d : 4'b0, on ? s : 8'h00,
                (c == 0) ? done0 : 1'b0, (c == 0) ? rdy0 : rdy1);
            if (c == br_at) brightness = br_new;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        ena        = 1'b0;
        wr_valid   = 1'b0;
        wr_data    = 16'h0000;
        wr_dp      = 4'b0000;
        brightness = 3'd7;
        #12;
        check_outs("reset", 4'b0, 8'h00, 1'b0, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        cyc("off_idle", 4'b0, 8'h00, 1'b0, 1'b1);
        ena = 1'b1;

        // Frame 1: blank display (all zeros), full brightness; frame A offered before digit 2.
        expect_slot("f1d0", 4'b0001, 8'h3F, 16, 1'b0, 1'b1, 1'b1, -1, 3'd0);
        expect_slot("f1d1", 4'b0010, 8'h3F, 16, 1'b0, 1'b1, 1'b1, -1, 3'd0);
        wr_data  = 16'h1234;
        wr_dp    = 4'b0001;
        wr_valid = 1'b1;
        expect_slot("f1d2", 4'b0100, 8'h3F, 16, 1'b0, 1'b0, 1'b0, -1, 3'd0);
        // Frame B held valid while A is still pending.
        wr_data = 16'hABCD;
        wr_dp   = 4'b1000;
        expect_slot("f1d3", 4'b1000, 8'h3F, 16, 1'b0, 1'b0, 1'b0, -1, 3'd0);

        // Frame 2 shows A; B is accepted one cycle after the boundary.
        expect_slot("f2d0", 4'b0001, 8'hE6, 16, 1'b1, 1'b1, 1'b0, -1, 3'd0);
        wr_valid = 1'b0;
        expect_slot("f2d1", 4'b0010, 8'h4F, 16, 1'b0, 1'b0, 1'b0, -1, 3'd0);
        expect_slot("f2d2", 4'b0100, 8'h5B, 16, 1'b0, 1'b0, 1'b0, -1, 3'd0);
        expect_slot("f2d3", 4'b1000, 8'h06, 16, 1'b0, 1'b0, 1'b0, -1, 3'd0);
        brightness = 3'd0;

        // Frame 3 shows B with brightness changes that only take effect at slot starts.
        expect_slot("f3d0", 4'b0001, 8'h5E, 2, 1'b1, 1'b1, 1'b1, -1, 3'd0);
        expect_slot("f3d1", 4'b0010, 8'h39, 2, 1'b0, 1'b1, 1'b1, 10, 3'd3);
        expect_slot("f3d2", 4'b0100, 8'h7C, 8, 1'b0, 1'b1, 1'b1, 6, 3'd0);
        expect_slot("f3d3", 4'b1000, 8'hF7, 2, 1'b0, 1'b1, 1'b1, 10, 3'd7);

        // Frame 4: frame C written at digit 1, then ena dropped during lit of digit 2.
        expect_slot("f4d0", 4'b0001, 8'h5E, 16, 1'b1, 1'b1, 1'b1, -1, 3'd0);
        wr_data  = 16'h80F9;
        wr_dp    = 4'b0100;
        wr_valid = 1'b1;
        expect_slot("f4d1", 4'b0010, 8'h39, 16, 1'b0, 1'b0, 1'b0, -1, 3'd0);
        wr_valid = 1'b0;
        for (int c = 0; c < 4; c++) cyc($sformatf("f4d2.c%0d", c), 4'b0, 8'h00, 1'b0, 1'b0);
        for (int c = 4; c < 7; c++) cyc($sformatf("f4d2.c%0d", c), 4'b0100, 8'h7C, 1'b0, 1'b0);
        ena = 1'b0;
        cyc("off0", 4'b0, 8'h00, 1'b0, 1'b0);
        cyc("off1", 4'b0, 8'h00, 1'b0, 1'b1);
        for (int c = 2; c < 24; c++) cyc($sformatf("off%0d", c), 4'b0, 8'h00, 1'b0, 1'b1);
        ena = 1'b1;

        // Restart from digit 0 showing C, copied while off.
        expect_slot("c_d0", 4'b0001, 8'h6F, 16, 1'b0, 1'b1, 1'b1, -1, 3'd0);
        expect_slot("c_d1", 4'b0010, 8'h71, 16, 1'b0, 1'b1, 1'b1, -1, 3'd0);
        expect_slot("c_d2", 4'b0100, 8'hBF, 16, 1'b0, 1'b1, 1'b1, -1, 3'd0);
        expect_slot("c_d3", 4'b1000, 8'h7F, 16, 1'b0, 1'b1, 1'b1, -1, 3'd0);

        // Frame D pending, then asynchronous reset in the middle of digit 1's lit phase.
        wr_data  = 16'h1111;
        wr_dp    = 4'b1111;
        wr_valid = 1'b1;
        expect_slot("g_d0", 4'b0001, 8'h6F, 16, 1'b1, 1'b0, 1'b0, -1, 3'd0);
        wr_valid = 1'b0;
        for (int c = 0; c < 4; c++) cyc($sformatf("g_d1.c%0d", c), 4'b0, 8'h00, 1'b0, 1'b0);
        for (int c = 4; c < 6; c++) cyc($sformatf("g_d1.c%0d", c), 4'b0010, 8'h71, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 4'b0, 8'h00, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;

        // After reset the display is all zeros and the lost frame D never appears.
        expect_slot("r_d0", 4'b0001, 8'h3F, 16, 1'b0, 1'b1, 1'b1, -1, 3'd0);
        expect_slot("r_d1", 4'b0010, 8'h3F, 16, 1'b0, 1'b1, 1'b1, -1, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
